// File: rtl/rn_seq_pkg.sv
// Shared types and constants for the ordered reset-release sequencer.
package rn_seq_pkg;

  typedef enum logic [2:0] {
    HOLD        = 3'd0,
    RELEASE     = 3'd1,
    RUN         = 3'd2,
    SRST_ASSERT = 3'd3,
    SRST_WAIT   = 3'd4
  } rn_state_e;

  localparam int unsigned NDOM_DEF       = 4;
  localparam int unsigned ASSERT_CYC_DEF = 8;
  localparam int unsigned STEP_CYC_DEF   = 4;

  // Bits needed to hold values 0..maxval, never less than one.
  function automatic int unsigned width_for(input int unsigned maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

endpackage

// File: rtl/rn_seq_timer.sv
// Saturating up-counter with synchronous clear and a registered terminal-count flag.
module rn_seq_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic [CW-1:0] tc_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;

  // done reflects the count that will be held after this edge, so it is valid
  // in the same cycle the counter reaches tc_i.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q < tc_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
    done_d = (cnt_d == tc_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      done_q <= (tc_i == '0);
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/rn_release_sequencer.sv
// Holds NDOM reset domains low, then releases them one by one in index order,
// with a four-phase software reset request/acknowledge handshake.
module rn_release_sequencer
  import rn_seq_pkg::*;
#(
  parameter int unsigned NDOM       = NDOM_DEF,
  parameter int unsigned ASSERT_CYC = ASSERT_CYC_DEF,
  parameter int unsigned STEP_CYC   = STEP_CYC_DEF
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            SRST_REQ,
  output logic            SRST_ACK,
  output logic [NDOM-1:0] DOM_RN,
  output logic            ALL_RELEASED
);

  localparam int unsigned CW = width_for((ASSERT_CYC > STEP_CYC) ? ASSERT_CYC : STEP_CYC);
  localparam int unsigned IW = width_for(NDOM);

  localparam logic [CW-1:0] TC_ASSERT = CW'(ASSERT_CYC - 1);
  localparam logic [CW-1:0] TC_STEP   = CW'(STEP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDOM - 1);

  localparam logic [2:0] S_HOLD        = HOLD;
  localparam logic [2:0] S_RELEASE     = RELEASE;
  localparam logic [2:0] S_RUN         = RUN;
  localparam logic [2:0] S_SRST_ASSERT = SRST_ASSERT;
  localparam logic [2:0] S_SRST_WAIT   = SRST_WAIT;

  if (NDOM < 1 || ASSERT_CYC < 1 || STEP_CYC < 1) begin : g_bad_param
    $error("rn_release_sequencer: NDOM, ASSERT_CYC and STEP_CYC must all be >= 1");
  end

  logic [2:0]      state_q, state_d, st_eff;
  logic [NDOM-1:0] dom_q, dom_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            ack_q, ack_d;
  logic            all_q;
  logic            tmr_clr, tmr_en, tmr_done;
  logic [CW-1:0]   tmr_tc;

  rn_seq_timer #(.CW(CW)) u_timer (
    .clk_i  (CLK),
    .rst_ni (RN),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .tc_i   (tmr_tc),
    .done_o (tmr_done)
  );

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    case (state_q)
      // HOLD always carries idx=0, so it shares the release path with RELEASE.
      S_HOLD, S_RELEASE: begin
        tmr_en = 1'b1;
        if (SRST_REQ) begin
          state_d = S_SRST_ASSERT;
          dom_d   = '0;
          tmr_clr = 1'b1;
        end else if (tmr_done) begin
          dom_d   = (dom_q << 1) | NDOM'(1);
          tmr_clr = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = S_RUN;
          end else begin
            state_d = S_RELEASE;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_RUN: begin
        if (SRST_REQ) begin
          state_d = S_SRST_ASSERT;
          dom_d   = '0;
          tmr_clr = 1'b1;
        end
      end
      S_SRST_ASSERT: begin
        tmr_en = 1'b1;
        if (tmr_done) begin
          state_d = S_SRST_WAIT;
          ack_d   = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      S_SRST_WAIT: begin
        if (!SRST_REQ) begin
          state_d = S_RELEASE;
          ack_d   = 1'b0;
          idx_d   = '0;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_HOLD;
        dom_d   = '0;
        idx_d   = '0;
        ack_d   = 1'b0;
        tmr_clr = 1'b1;
      end
    endcase
    // The timer compare follows the state being entered so its done flag is
    // already correct for that state.
    st_eff = RN ? state_d : S_HOLD;
    tmr_tc = (st_eff == S_RELEASE) ? TC_STEP : TC_ASSERT;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= S_HOLD;
      dom_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      all_q   <= &dom_d;
    end
  end

  assign DOM_RN       = dom_q;
  assign SRST_ACK     = ack_q;
  assign ALL_RELEASED = all_q;

endmodule

// File: tb/tb_rn_release_sequencer.sv
// Directed scoreboard bench for the reset release sequencer (4-domain and 1-domain builds).
module tb_rn_release_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn, req, ack, all;
  logic [3:0] dom;
  logic       rn1, req1, ack1, all1;
  logic [0:0] dom1;

  rn_release_sequencer #(.NDOM(4), .ASSERT_CYC(8), .STEP_CYC(4)) dut (
    .CLK          (clk),
    .RN           (rn),
    .SRST_REQ     (req),
    .SRST_ACK     (ack),
    .DOM_RN       (dom),
    .ALL_RELEASED (all)
  );

  rn_release_sequencer #(.NDOM(1), .ASSERT_CYC(1), .STEP_CYC(1)) dut1 (
    .CLK          (clk),
    .RN           (rn1),
    .SRST_REQ     (req1),
    .SRST_ACK     (ack1),
    .DOM_RN       (dom1),
    .ALL_RELEASED (all1)
  );

  typedef struct {
    string      tag;
    int         e;
    bit         sel;
    logic [5:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input int e, input bit sel,
                      input logic [3:0] d, input logic a, input logic k);
    exp_t x;
    x.tag = tag;
    x.e   = e;
    x.sel = sel;
    x.val = {d, a, k};
    sb.push_back(x);
  endtask

  // Expected 4-domain trace: bit k rises on edge first+step*k, ACK high on edges ack_lo..ack_hi.
  task automatic push_trace(input string tag, input int n, input int first, input int step,
                            input int ack_lo, input int ack_hi);
    logic [3:0] d;
    for (int e = 1; e <= n; e++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        if (e >= first + step * k) d[k] = 1'b1;
      end
      push(tag, e, 1'b0, d, (e >= first + step * 3), (e >= ack_lo && e <= ack_hi));
    end
  endtask

  // Advance n edges, dropping both requests just after edge drop_after, and
  // compare each edge's outputs against the next scoreboard entry.
  task automatic go(input int n, input int drop_after);
    exp_t       x;
    logic [5:0] obs;
    for (int e = 1; e <= n; e++) begin
      @(posedge clk);
      #1;
      if (e == drop_after) begin
        req  = 1'b0;
        req1 = 1'b0;
      end
      @(negedge clk);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $error("FAIL scoreboard_empty: got an output edge, required a queued expectation");
      end else begin
        x   = sb.pop_front();
        obs = x.sel ? {3'b000, dom1, all1, ack1} : {dom, all, ack};
        assert (obs === x.val)
        else begin
          bad++;
          $error("FAIL %s edge %0d: {dom,all,ack} got %b required %b", x.tag, x.e, obs, x.val);
        end
      end
    end
  endtask

  initial begin
    rn   = 1'b0;
    req  = 1'b0;
    rn1  = 1'b0;
    req1 = 1'b0;

    for (int e = 1; e <= 3; e++) push("reset", e, 1'b0, 4'b0000, 1'b0, 1'b0);
    go(3, 0);

    rn = 1'b1;
    push_trace("power_on", 22, 8, 4, 0, -1);
    go(22, 0);

    rn = 1'b0;
    for (int e = 1; e <= 3; e++) push("reset2", e, 1'b0, 4'b0000, 1'b0, 1'b0);
    go(3, 0);
    rn = 1'b1;
    push_trace("restart", 13, 8, 4, 0, -1);
    go(13, 0);
    rn = 1'b0;
    push("rn_drop", 1, 1'b0, 4'b0000, 1'b0, 1'b0);
    go(1, 0);
    rn = 1'b1;
    push_trace("resume", 22, 8, 4, 0, -1);
    go(22, 0);

    req = 1'b1;
    push_trace("srst_short", 28, 14, 4, 9, 9);
    go(28, 2);

    req = 1'b1;
    push_trace("srst_long", 38, 25, 4, 9, 20);
    go(38, 20);

    rn = 1'b0;
    for (int e = 1; e <= 2; e++) push("reset3", e, 1'b0, 4'b0000, 1'b0, 1'b0);
    go(2, 0);
    rn = 1'b1;
    push_trace("pre_race", 15, 8, 4, 0, -1);
    go(15, 0);
    req = 1'b1;
    push_trace("race", 28, 14, 4, 9, 9);
    go(28, 1);

    rn1 = 1'b1;
    push("n1_release", 1, 1'b1, 4'b0001, 1'b1, 1'b0);
    go(1, 0);
    req1 = 1'b1;
    push("n1_srst", 2, 1'b1, 4'b0000, 1'b0, 1'b0);
    push("n1_ack",  3, 1'b1, 4'b0000, 1'b0, 1'b1);
    push("n1_done", 4, 1'b1, 4'b0000, 1'b0, 1'b0);
    push("n1_rel2", 5, 1'b1, 4'b0001, 1'b1, 1'b0);
    push("n1_run",  6, 1'b1, 4'b0001, 1'b1, 1'b0);
    go(5, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
